// File: rtl/sbox_share_ctrl.sv
// Shares one byte-wide S-box between a 128-bit block port and a 32-bit word port.
// Jobs are serialised one byte per cycle and granted round-robin per job.
module sbox_share_ctrl #(
    parameter int SBOX_LAT = 0
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         blk_valid,
    output logic         blk_ready,
    input  logic         blk_encrypt,
    input  logic [127:0] blk_data,
    output logic         blk_done,
    output logic [127:0] blk_result,
    input  logic         wrd_valid,
    output logic         wrd_ready,
    input  logic [31:0]  wrd_data,
    output logic         wrd_done,
    output logic [31:0]  wrd_result,
    output logic         sbox_encrypt,
    output logic [7:0]   sbox_in,
    input  logic [7:0]   sbox_out,
    output logic         busy
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } state_t;

    localparam logic BLK = 1'b0;
    localparam logic WRD = 1'b1;

    state_t         state;
    state_t         state_nxt;
    logic [127:0]   work;
    logic           owner;
    logic           mode;
    logic           last_grant;
    logic [3:0]     cnt;
    logic [3:0]     last_idx;
    logic           is_last;
    logic           accept;
    logic           cap_v_q;
    logic [3:0]     cap_idx_q;
    logic           cap_en;
    logic [3:0]     cap_idx;

    assign last_idx = (owner == WRD) ? 4'd3 : 4'd15;
    assign is_last  = (cnt == last_idx);
    assign accept   = blk_ready | wrd_ready;

    // With a registered S-box the result of byte k arrives one cycle late.
    assign cap_en  = (SBOX_LAT == 1) ? cap_v_q : (state == RUN);
    assign cap_idx = (SBOX_LAT == 1) ? cap_idx_q : cnt;

    always_comb begin
        state_nxt    = state;
        blk_ready    = 1'b0;
        wrd_ready    = 1'b0;
        blk_done     = 1'b0;
        wrd_done     = 1'b0;
        sbox_in      = 8'h00;
        sbox_encrypt = 1'b1;
        busy         = (state != IDLE);
        unique case (state)
            IDLE: begin
                blk_ready = blk_valid & (~wrd_valid | (last_grant == WRD));
                wrd_ready = wrd_valid & (~blk_valid | (last_grant == BLK));
                if (blk_ready | wrd_ready) state_nxt = RUN;
            end
            RUN: begin
                sbox_in      = work[{cnt, 3'b000} +: 8];
                sbox_encrypt = mode;
                if (is_last) state_nxt = (SBOX_LAT == 1) ? DRAIN : DONE;
            end
            DRAIN: state_nxt = DONE;
            DONE: begin
                blk_done  = (owner == BLK);
                wrd_done  = (owner == WRD);
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            work       <= '0;
            owner      <= BLK;
            mode       <= 1'b1;
            last_grant <= BLK;
            cnt        <= 4'd0;
            cap_v_q    <= 1'b0;
            cap_idx_q  <= 4'd0;
            blk_result <= '0;
            wrd_result <= '0;
        end else begin
            state     <= state_nxt;
            cap_v_q   <= (state == RUN);
            cap_idx_q <= cnt;
            if (accept) begin
                owner      <= wrd_ready;
                mode       <= wrd_ready | blk_encrypt;
                last_grant <= wrd_ready;
                cnt        <= 4'd0;
                work       <= wrd_ready ? {96'b0, wrd_data} : blk_data;
            end else if (state == RUN && !is_last) begin
                cnt <= cnt + 4'd1;
            end
            if (cap_en) begin
                if (owner == WRD)
                    wrd_result[{cap_idx[1:0], 3'b000} +: 8] <= sbox_out;
                else
                    blk_result[{cap_idx, 3'b000} +: 8] <= sbox_out;
            end
        end
    end

endmodule

// File: tb/tb_sbox_share_ctrl.sv
// Bench for sbox_share_ctrl: one combinational-S-box instance and one
// registered-S-box instance, checked against a GF(2^8)-derived S-box model.
module tb_sbox_share_ctrl;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         sel;
    logic         blk_valid, blk_encrypt, wrd_valid;
    logic [127:0] blk_data;
    logic [31:0]  wrd_data;

    logic         br0, br1, bd0, bd1, wr0, wr1, wd0, wd1;
    logic         se0, se1, bz0, bz1;
    logic [127:0] bres0, bres1;
    logic [31:0]  wres0, wres1;
    logic [7:0]   sin0, sin1, sout0, sout1;

    logic         blk_ready, blk_done, wrd_ready, wrd_done;
    logic         sbox_encrypt, busy;
    logic [127:0] blk_result;
    logic [31:0]  wrd_result;
    logic [7:0]   sbox_in;

    logic [7:0]   fwd [256];
    logic [7:0]   invt[256];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sbox_share_ctrl #(.SBOX_LAT(0)) dut0 (
        .clk(clk), .reset_n(reset_n),
        .blk_valid(blk_valid & ~sel), .blk_ready(br0),
        .blk_encrypt(blk_encrypt), .blk_data(blk_data),
        .blk_done(bd0), .blk_result(bres0),
        .wrd_valid(wrd_valid & ~sel), .wrd_ready(wr0),
        .wrd_data(wrd_data), .wrd_done(wd0), .wrd_result(wres0),
        .sbox_encrypt(se0), .sbox_in(sin0), .sbox_out(sout0),
        .busy(bz0)
    );

    sbox_share_ctrl #(.SBOX_LAT(1)) dut1 (
        .clk(clk), .reset_n(reset_n),
        .blk_valid(blk_valid & sel), .blk_ready(br1),
        .blk_encrypt(blk_encrypt), .blk_data(blk_data),
        .blk_done(bd1), .blk_result(bres1),
        .wrd_valid(wrd_valid & sel), .wrd_ready(wr1),
        .wrd_data(wrd_data), .wrd_done(wd1), .wrd_result(wres1),
        .sbox_encrypt(se1), .sbox_in(sin1), .sbox_out(sout1),
        .busy(bz1)
    );

    assign sout0 = se0 ? fwd[sin0] : invt[sin0];
    always @(posedge clk) sout1 <= se1 ? fwd[sin1] : invt[sin1];

    assign blk_ready    = sel ? br1 : br0;
    assign blk_done     = sel ? bd1 : bd0;
    assign blk_result   = sel ? bres1 : bres0;
    assign wrd_ready    = sel ? wr1 : wr0;
    assign wrd_done     = sel ? wd1 : wd0;
    assign wrd_result   = sel ? wres1 : wres0;
    assign sbox_encrypt = sel ? se1 : se0;
    assign sbox_in      = sel ? sin1 : sin0;
    assign busy         = sel ? bz1 : bz0;

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x, y;
        p = 8'h00; x = a; y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
            y = y >> 1;
        end
        return p;
    endfunction

    task automatic build_tables();
        logic [7:0] b, s;
        for (int x = 0; x < 256; x++) begin
            b = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gmul(8'(x), 8'(y)) == 8'h01) b = 8'(y);
            s = b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]}
                  ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
            fwd[x]  = s;
            invt[s] = 8'(x);
        end
    endtask

    function automatic logic [127:0] ref_sub(input logic [127:0] d, input bit enc, input int n);
        logic [127:0] r;
        r = '0;
        for (int i = 0; i < n; i++)
            r[8*i +: 8] = enc ? fwd[d[8*i +: 8]] : invt[d[8*i +: 8]];
        return r;
    endfunction

    task automatic do_reset();
        reset_n   = 1'b0;
        blk_valid = 1'b0;
        wrd_valid = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
    endtask

    // Drives one job on the selected instance and checks latency, done
    // exclusivity, word-mode encrypt forcing and the substituted result.
    task automatic run_job(input bit w, input logic [127:0] d, input bit enc,
                           input string nm, output logic [127:0] res);
        int n, lat, c, got, extra;
        bit bad_other, bad_enc, bad_both;
        logic [127:0] exp;
        n = w ? 4 : 16;
        lat = sel ? 1 : 0;
        exp = ref_sub(d, w ? 1'b1 : enc, n);
        res = '0;
        @(negedge clk);
        if (w) begin wrd_valid = 1'b1; wrd_data = d[31:0]; end
        else begin blk_valid = 1'b1; blk_data = d; blk_encrypt = enc; end
        #1;
        c = 0;
        while (!(w ? wrd_ready : blk_ready) && c < 20) begin
            @(negedge clk); #1; c++;
        end
        checks++;
        if (!(w ? wrd_ready : blk_ready)) begin
            errors++;
            $display("FAIL %s ready: got 0 expected 1 within 20 cycles", nm);
            blk_valid = 1'b0; wrd_valid = 1'b0;
            return;
        end
        @(posedge clk); #1;
        blk_valid = 1'b0; wrd_valid = 1'b0;
        blk_data = {$urandom, $urandom, $urandom, $urandom};
        wrd_data = $urandom;
        blk_encrypt = w ? 1'b0 : 1'($urandom);
        got = -1; extra = 0;
        bad_other = 0; bad_enc = 0; bad_both = 0;
        for (c = 1; c <= n + 4; c++) begin
            @(negedge clk); #1;
            if (w ? wrd_done : blk_done) begin
                if (got < 0) got = c; else extra++;
            end
            if (w ? blk_done : wrd_done) bad_other = 1;
            if (w && busy && !sbox_encrypt) bad_enc = 1;
            if (blk_ready && wrd_ready) bad_both = 1;
        end
        checks++;
        if (got != n + 1 + lat || extra != 0) begin
            errors++;
            $display("FAIL %s latency: got %0d (extra pulses %0d) expected %0d",
                     nm, got, extra, n + 1 + lat);
        end
        checks++;
        if (bad_other) begin
            errors++;
            $display("FAIL %s other_done: got 1 expected 0", nm);
        end
        checks++;
        if (bad_enc || bad_both) begin
            errors++;
            $display("FAIL %s enc/ready: enc_low=%0d both_ready=%0d expected 0 0",
                     nm, bad_enc, bad_both);
        end
        res = w ? {96'b0, wrd_result} : blk_result;
        checks++;
        if (res !== exp) begin
            errors++;
            $display("FAIL %s result: got %h expected %h", nm, res, exp);
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0; blk_valid = 1'b0; wrd_valid = 1'b0;
        @(negedge clk); #1;
        checks++;
        if ({bz0, br0, wr0, bd0, wd0, se0, sin0} !== {6'b000001, 8'h00} ||
            bres0 !== '0 || wres0 !== '0) begin
            errors++;
            $display("FAIL reset0: got busy=%b rdy=%b%b done=%b%b enc=%b in=%h expected 0 00 00 1 00",
                     bz0, br0, wr0, bd0, wd0, se0, sin0);
        end
        checks++;
        if ({bz1, br1, wr1, bd1, wd1, se1, sin1} !== {6'b000001, 8'h00} ||
            bres1 !== '0 || wres1 !== '0) begin
            errors++;
            $display("FAIL reset1: got busy=%b rdy=%b%b done=%b%b enc=%b in=%h expected 0 00 00 1 00",
                     bz1, br1, wr1, bd1, wd1, se1, sin1);
        end
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic test_block_vectors();
        logic [127:0] r;
        sel = 1'b0;
        run_job(1'b0, '0, 1'b1, "blk_enc_zero", r);
        checks++;
        if (r !== {16{8'h63}}) begin
            errors++; $display("FAIL blk_enc_zero const: got %h expected 63..63", r);
        end
        run_job(1'b0, {16{8'h63}}, 1'b0, "blk_dec_63", r);
        checks++;
        if (r !== '0) begin
            errors++; $display("FAIL blk_dec_63 const: got %h expected 0", r);
        end
        run_job(1'b0, {120'b0, 8'hed}, 1'b0, "blk_dec_ed", r);
        checks++;
        if (r !== {{15{8'h52}}, 8'h53}) begin
            errors++; $display("FAIL blk_dec_ed const: got %h expected 52..5253", r);
        end
    endtask

    task automatic test_word();
        logic [127:0] r;
        sel = 1'b0;
        blk_encrypt = 1'b0;
        run_job(1'b1, {96'b0, 32'h01020304}, 1'b0, "wrd_vec", r);
        checks++;
        if (r[31:0] !== 32'h7c777bf2) begin
            errors++; $display("FAIL wrd_vec const: got %h expected 7c777bf2", r[31:0]);
        end
    endtask

    task automatic test_lat1();
        logic [127:0] d, r;
        sel = 1'b1;
        for (int i = 0; i < 16; i++) d[8*i +: 8] = 8'(i);
        run_job(1'b0, d, 1'b1, "lat1_blk", r);
        checks++;
        if (r[7:0] !== 8'h63 || r[15:8] !== 8'h7c || r[127:120] !== 8'h76) begin
            errors++;
            $display("FAIL lat1_blk const: got b0=%h b1=%h b15=%h expected 63 7c 76",
                     r[7:0], r[15:8], r[127:120]);
        end
        run_job(1'b1, {96'b0, 32'h01020304}, 1'b0, "lat1_wrd", r);
    endtask

    task automatic test_back_to_back(input bit s);
        int t, prev_t, prev_n, n_acc;
        bit last, k;
        logic [127:0] bdat;
        logic [31:0]  wdat;
        sel = s;
        bdat = {$urandom, $urandom, $urandom, $urandom};
        wdat = $urandom;
        reset_n = 1'b0;
        blk_valid = 1'b1; wrd_valid = 1'b1;
        blk_encrypt = 1'b1; blk_data = bdat; wrd_data = wdat;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        #1;
        last = 1'b0;
        n_acc = 0; t = 0; prev_t = 0; prev_n = 0;
        while (n_acc < 4 && t < 200) begin
            checks++;
            if (blk_ready && wrd_ready) begin
                errors++; $display("FAIL b2b both_ready: got 11 expected at most one");
            end
            if (blk_ready || wrd_ready) begin
                k = wrd_ready;
                checks++;
                if (k != !last) begin
                    errors++; $display("FAIL b2b order: got wrd=%0d expected wrd=%0d", k, !last);
                end
                if (n_acc > 0) begin
                    checks++;
                    if (t - prev_t != prev_n + 2 + int'(s)) begin
                        errors++;
                        $display("FAIL b2b interval: got %0d expected %0d",
                                 t - prev_t, prev_n + 2 + int'(s));
                    end
                end
                prev_t = t; prev_n = k ? 4 : 16; last = k; n_acc++;
                if (n_acc == 4) break;
            end
            @(negedge clk); #1; t++;
        end
        @(posedge clk); #1;
        blk_valid = 1'b0; wrd_valid = 1'b0;
        checks++;
        if (n_acc != 4) begin
            errors++; $display("FAIL b2b grants: got %0d expected 4", n_acc);
        end
        repeat (24) @(negedge clk);
        #1;
        checks++;
        if (blk_result !== ref_sub(bdat, 1'b1, 16) ||
            wrd_result !== ref_sub({96'b0, wdat}, 1'b1, 4)) begin
            errors++;
            $display("FAIL b2b results: got %h %h expected %h %h", blk_result, wrd_result,
                     ref_sub(bdat, 1'b1, 16), ref_sub({96'b0, wdat}, 1'b1, 4)[31:0]);
        end
    endtask

    task automatic test_random();
        logic [127:0] r, d;
        bit w;
        for (int s = 0; s < 2; s++) begin
            sel = 1'(s);
            for (int j = 0; j < 6; j++) begin
                w = 1'($urandom);
                d = {$urandom, $urandom, $urandom, $urandom};
                run_job(w, d, 1'($urandom), "rand_job", r);
            end
        end
    endtask

    task automatic test_mid_reset();
        logic [127:0] d, r;
        bit seen_done;
        int c;
        sel = 1'b0;
        d = {$urandom, $urandom, $urandom, $urandom};
        @(negedge clk);
        blk_valid = 1'b1; blk_data = d; blk_encrypt = 1'b1;
        #1;
        c = 0;
        while (!blk_ready && c < 20) begin @(negedge clk); #1; c++; end
        @(posedge clk); #1;
        blk_valid = 1'b0;
        repeat (8) @(negedge clk);
        #1;
        checks++;
        if (busy !== 1'b1 || sbox_in !== d[63:56]) begin
            errors++;
            $display("FAIL midrst issue7: got busy=%b in=%h expected 1 %h", busy, sbox_in, d[63:56]);
        end
        reset_n = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || sbox_in !== 8'h00 || blk_result !== '0 || sbox_encrypt !== 1'b1) begin
            errors++;
            $display("FAIL midrst outputs: got busy=%b in=%h res=%h enc=%b expected 0 00 0 1",
                     busy, sbox_in, blk_result, sbox_encrypt);
        end
        seen_done = 0;
        repeat (2) begin @(negedge clk); #1; if (blk_done) seen_done = 1; end
        reset_n = 1'b1;
        repeat (20) begin @(negedge clk); #1; if (blk_done || busy) seen_done = 1; end
        checks++;
        if (seen_done) begin
            errors++; $display("FAIL midrst no_done: got activity expected none");
        end
        run_job(1'b1, {96'b0, 32'($urandom)}, 1'b0, "midrst_wrd", r);
    endtask

    task automatic test_drop_before_grant();
        bit started;
        sel = 1'b0;
        @(negedge clk);
        wrd_valid = 1'b1; wrd_data = $urandom;
        @(posedge clk); #1;
        wrd_valid = 1'b0;
        repeat (2) @(negedge clk);
        blk_valid = 1'b1;
        @(negedge clk);
        blk_valid = 1'b0;
        repeat (6) @(negedge clk);
        started = 0;
        repeat (10) begin @(negedge clk); #1; if (busy) started = 1; end
        checks++;
        if (started) begin
            errors++; $display("FAIL drop_before_grant: got busy=1 expected 0");
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        sel = 1'b0;
        blk_valid = 1'b0; wrd_valid = 1'b0; blk_encrypt = 1'b1;
        blk_data = '0; wrd_data = '0;
        reset_n = 1'b0;
        build_tables();
        test_reset();
        test_block_vectors();
        test_word();
        test_lat1();
        test_back_to_back(1'b0);
        test_back_to_back(1'b1);
        test_random();
        test_mid_reset();
        test_drop_before_grant();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sbox_share_ctrl.md
Name: sbox_share_ctrl

Overview:
- Time-multiplexes one external combined S-box/inverse S-box (8-bit in, 8-bit out, encrypt select) between two requesters.
  - Block port: 128-bit SubBytes/InvSubBytes for the round datapath.
  - Word port: 32-bit SubWord for key expansion, always forward S-box.
- Serialises one byte per cycle into the S-box and reassembles the result.
- Arbitrates round-robin at job granularity.
- Sits between the round/key-schedule control and the single shared S-box instance.

Parameters:
- SBOX_LAT, 0: S-box path latency in cycles. 0 = combinational. 1 = registered output, where sbox_out reflects the sbox_in/sbox_encrypt of the previous cycle. Other values are illegal.

Ports:
- clk  in  1  clock, all state on rising edge
- reset_n  in  1  asynchronous active-low reset
- blk_valid  in  1  block job request
- blk_ready  out  1  block job accepted this cycle when high together with blk_valid
- blk_encrypt  in  1  1 = forward S-box, 0 = inverse; sampled at accept
- blk_data  in  128  input state; byte i = bits [8i+7:8i]
- blk_done  out  1  one-cycle pulse, blk_result valid
- blk_result  out  128  substituted state; held until next block job completes
- wrd_valid  in  1  word job request
- wrd_ready  out  1  word job accepted
- wrd_data  in  32  input word; byte i = bits [8i+7:8i]
- wrd_done  out  1  one-cycle pulse
- wrd_result  out  32  substituted word; held until next word job completes
- sbox_encrypt  out  1  encrypt select to S-box
- sbox_in  out  8  byte to S-box
- sbox_out  in  8  byte from S-box
- busy  out  1  high in any state other than IDLE

Behaviour:
- Reset values:
  - state=IDLE
  - blk_ready=0, wrd_ready=0, blk_done=0, wrd_done=0
  - blk_result=0, wrd_result=0
  - sbox_in=0, sbox_encrypt=1, busy=0
  - last_grant=BLK, so the word port wins the first tie.
- States:
  - IDLE → RUN on accept.
  - RUN → DRAIN when the last byte has been issued and SBOX_LAT=1.
  - RUN → DONE when the last byte has been issued and SBOX_LAT=0.
  - DRAIN → DONE after 1 cycle.
  - DONE → IDLE after 1 cycle.
- Ready is combinational and asserted only in IDLE:
  - blk_ready = IDLE & blk_valid & (!wrd_valid | last_grant==WRD)
  - wrd_ready = IDLE & wrd_valid & (!blk_valid | last_grant==BLK)
  - At most one ready is high per cycle. last_grant updates on accept.
- On accept, the controller latches:
  - job data into a 128-bit work register (word jobs use the low 32 bits)
  - owner (BLK/WRD)
  - mode: blk_encrypt for block jobs, forced 1 for word jobs
  - byte count N (16 or 4)
  - Requester inputs may change freely after the accept cycle.
- Issue (RUN):
  - In RUN cycle k (k=0..N-1): sbox_in = work byte k, sbox_encrypt = latched mode.
  - Outside RUN: sbox_in=0, sbox_encrypt=1.
- Capture:
  - SBOX_LAT=0: byte k is captured from sbox_out at the end of RUN cycle k.
  - SBOX_LAT=1: byte k is captured at the end of the following cycle, so the last capture happens in DRAIN.
  - Captured byte k is written into result position k of the owner's result register only when that byte is captured. The register is updated in place, so bytes not yet captured keep their old values.
  - The result register is only guaranteed coherent while done is high and after it.
- Done:
  - The owner's done pulses high for exactly the DONE cycle.
  - The other port's done stays 0.
- Latency:
  - If the accept is in cycle t, done is high in cycle t+N+1+SBOX_LAT.
  - The next accept is possible no earlier than t+N+2+SBOX_LAT.
  - Block job: 17 or 18 cycles. Word job: 5 or 6 cycles.
- Byte counter: 4 bits; terminal value N-1; no wrap beyond N-1.
- Simultaneous request at the done cycle: not accepted until IDLE; no accept during DONE.
- Valid dropped before grant: no job starts and no state changes; requests need not be held.
- Reset mid-job: in-flight job discarded, all outputs return to reset values immediately, no done pulse.

Test Plan:
- Block encrypt, blk_data=all 0x00, SBOX_LAT=0 → blk_done exactly 17 cycles after accept, blk_result = 0x6363…63; wrd_done stays 0.
- Block decrypt, blk_data=all 0x63 → blk_result all 0x00; then byte0=0xED, others 0x00 → result byte0=0x53, others 0x52.
- Word job wrd_data=0x01020304 → wrd_result=0x7C777BF2, wrd_done 5 cycles after accept; sbox_encrypt=1 throughout the job even if blk_encrypt=0.
- blk_valid and wrd_valid held high together from reset → grant order WRD, BLK, WRD, BLK; each accept exactly N+2 cycles after the previous one; never both readies high.
- SBOX_LAT=1 with a one-cycle registered S-box model, block encrypt of byte i = i → result byte i = FIPS-197 S-box(i) (e.g. byte0=0x63, byte1=0x7C, byte15=0x76), done at t+18.
- Assert reset_n low in RUN cycle 7 of a block job → busy=0, sbox_in=0, blk_result=0, no blk_done; a fresh word job afterwards completes correctly.
